// File: rtl/lsu_pkg.sv
// Shared types for the load/store burst engine: FSM state encoding and the
// legacy ld/st/ldp/stp sub-op decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StRdDrain,
        StWr
    } lsu_state_e;

    localparam logic [3:0] LD  = 4'b0000;
    localparam logic [3:0] ST  = 4'b0001;
    localparam logic [3:0] LDP = 4'b0010;
    localparam logic [3:0] STP = 4'b0011;

    typedef struct packed {
        logic       store;
        logic [3:0] len;
    } subop_dec_t;

    // Maps the fixed one/two-word sub-ops onto a burst request (len is words minus one).
    function automatic subop_dec_t subop_decode(input logic [3:0] op);
        subop_dec_t dec;
        dec.store = (op == ST) || (op == STP);
        dec.len   = ((op == LDP) || (op == STP)) ? 4'd1 : 4'd0;
        return dec;
    endfunction

endpackage

// File: rtl/lsu_burst_if.sv
// Request, data-memory and register-file ports of the burst engine.
// The master modport is the burst engine itself; slave is its surroundings.
interface lsu_burst_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned MAX_BURST = 4
);
    localparam int unsigned LEN_W = $clog2(MAX_BURST);

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [LEN_W-1:0]  req_len;
    logic [ADDR_W-1:0] req_addr;
    logic [REG_AW-1:0] req_reg;

    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [REG_AW-1:0] reg_raddr;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_wen;
    logic [REG_AW-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;

    logic              busy;
    logic              done;

    modport master (
        input  req_valid, req_store, req_len, req_addr, req_reg,
        input  mem_rdata, reg_rdata,
        output req_ready, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        output reg_raddr, reg_wen, reg_waddr, reg_wdata, busy, done
    );

    modport slave (
        output req_valid, req_store, req_len, req_addr, req_reg,
        output mem_rdata, reg_rdata,
        input  req_ready, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        input  reg_raddr, reg_wen, reg_waddr, reg_wdata, busy, done
    );

endinterface

// File: rtl/lsu_beat_ctr.sv
// Beat counter for a burst: latches the length on accept, steps once per beat
// and flags the final and second-to-final beats.
module lsu_beat_ctr #(
    parameter int unsigned LEN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] beat,
    output logic             last,
    output logic             penult
);

    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            len_q  <= '0;
        end else if (load) begin
            beat_q <= '0;
            len_q  <= len;
        end else if (inc) begin
            beat_q <= beat_q + LEN_W'(1);
        end
    end

    assign beat   = beat_q;
    assign last   = (beat_q == len_q);
    // Only meaningful while beat < len, so the wrap of beat+1 never matters.
    assign penult = ((beat_q + LEN_W'(1)) == len_q);

endmodule

// File: rtl/lsu_burst.sv
// Multicycle load/store burst engine: moves 1..MAX_BURST consecutive words
// between data memory and consecutive registers, stalling the pipeline via busy.
module lsu_burst
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_burst_if.master bus
);

    localparam int unsigned LEN_W = $clog2(MAX_BURST);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] base_addr_q;
    logic [REG_AW-1:0] base_reg_q;

    logic [ADDR_W-1:0] mem_raddr_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [REG_AW-1:0] reg_raddr_q;
    logic              reg_wen_q;
    logic [REG_AW-1:0] reg_waddr_q;
    logic              done_q;

    logic [LEN_W-1:0]  beat;
    logic [LEN_W-1:0]  beat_nxt;
    logic              last;
    logic              penult;
    logic              ctr_load;
    logic              ctr_inc;

    assign ctr_load = (state_q == StIdle) && bus.req_valid;
    assign ctr_inc  = ((state_q == StRd) || (state_q == StWr)) && !last;
    assign beat_nxt = beat + LEN_W'(1);

    lsu_beat_ctr #(
        .LEN_W (LEN_W)
    ) u_beat_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ctr_load),
        .inc    (ctr_inc),
        .len    (bus.req_len),
        .beat   (beat),
        .last   (last),
        .penult (penult)
    );

    // Outputs for beat k are registered at the edge that opens beat k's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_addr_q <= '0;
            base_reg_q  <= '0;
            mem_raddr_q <= '0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
            reg_raddr_q <= '0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    reg_wen_q <= 1'b0;
                    mem_wen_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (bus.req_valid) begin
                        base_addr_q <= bus.req_addr;
                        base_reg_q  <= bus.req_reg;
                        if (bus.req_store) begin
                            state_q     <= StWr;
                            mem_wen_q   <= 1'b1;
                            mem_waddr_q <= bus.req_addr;
                            reg_raddr_q <= bus.req_reg;
                            done_q      <= (bus.req_len == '0);
                        end else begin
                            state_q     <= StRd;
                            mem_raddr_q <= bus.req_addr;
                        end
                    end
                end
                StRd: begin
                    // Write back the word read during this beat; it arrives next cycle.
                    reg_wen_q   <= 1'b1;
                    reg_waddr_q <= base_reg_q + REG_AW'(beat);
                    if (last) begin
                        state_q <= StRdDrain;
                        done_q  <= 1'b1;
                    end else begin
                        mem_raddr_q <= base_addr_q + ADDR_W'(beat_nxt);
                    end
                end
                StRdDrain: begin
                    state_q   <= StIdle;
                    reg_wen_q <= 1'b0;
                    done_q    <= 1'b0;
                end
                StWr: begin
                    if (last) begin
                        state_q   <= StIdle;
                        mem_wen_q <= 1'b0;
                        done_q    <= 1'b0;
                    end else begin
                        mem_waddr_q <= base_addr_q + ADDR_W'(beat_nxt);
                        reg_raddr_q <= base_reg_q + REG_AW'(beat_nxt);
                        done_q      <= penult;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Ready is gated by reset so the pipeline never sees a handshake while held in reset.
    assign bus.req_ready = rst_n && (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;

    assign bus.mem_raddr = mem_raddr_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wen_q ? bus.reg_rdata : '0;

    assign bus.reg_raddr = reg_raddr_q;
    assign bus.reg_wen   = reg_wen_q;
    assign bus.reg_waddr = reg_waddr_q;
    assign bus.reg_wdata = reg_wen_q ? bus.mem_rdata : '0;

endmodule
